// File: rtl/accumulator.sv
// Sums COUNT unsigned WIDTH-bit operands per block, sticky carry-out flag.
// Latency: result valid 1 cycle after the COUNT-th accepted operand.
// Backpressure: result held while out_ready=0; in_ready low until result taken (1-cycle bubble).
module accumulator #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow
);

    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_last;
    logic             w_first;
    logic [WIDTH:0]   w_sum;

    // Handshakes qualify on the registered ready/valid, so nothing is accepted
    // on the first edge after reset or on the edge the result leaves.
    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;
    assign w_first    = (r_count == '0);
    assign w_last     = w_in_xfer && (r_count == CW'(COUNT - 1));
    assign w_sum      = {1'b0, r_acc} + {1'b0, in_data};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: close the block on its last operand, reopen on result handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_last)     w_state_nxt = ST_DONE;
            ST_DONE:  if (w_out_xfer) w_state_nxt = ST_ACCUM;
            default:                  w_state_nxt = ST_ACCUM;
        endcase
    end

    // Registered handshake outputs follow the next state; in_ready stays low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_ACCUM);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Datapath: first operand loads, later ones add with sticky carry; count clears on output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_in_xfer) begin
            if (w_first) begin
                r_acc <= in_data;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_sum[WIDTH-1:0];
                r_ovf <= r_ovf | w_sum[WIDTH];
            end
            r_count <= r_count + CW'(1);
        end else if (w_out_xfer) begin
            r_count <= '0;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_sum      = r_acc;
    assign out_overflow = r_ovf;

endmodule

// File: doc/accumulator.md
ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001: Parameter WIDTH, default 8, is the operand and sum width in bits.
REQ-002: Parameter COUNT, default 4, is the number of operands summed per block; legal range 2..255.
REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low; one clock, the polarity and synchronicity are fixed.
REQ-005: in_valid  input  1  in_data carries an operand this cycle.
REQ-006: in_ready  output  1  block accepts an operand this cycle; registered.
REQ-007: in_data  input  WIDTH  unsigned operand.
REQ-008: out_valid  output  1  out_sum/out_overflow hold a completed block result; registered.
REQ-009: out_ready  input  1  downstream accepts the result this cycle.
REQ-010: out_sum  output  WIDTH  block sum modulo 2^WIDTH.
REQ-011: out_overflow  output  1  sticky carry-out flag for the block.

Function
REQ-012: Two states only: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-013: Input transfer occurs exactly on a rising edge with in_valid=1 and in_ready=1; in_valid/in_data are ignored otherwise.
REQ-014: First transfer of a block: acc <= in_data, overflow <= 0, count <= 1.
REQ-015: Each later transfer: acc <= (acc + in_data) mod 2^WIDTH; overflow <= overflow OR carry-out of that WIDTH-bit addition; count <= count + 1.
REQ-016: Overflow is sticky within a block: once set, it stays 1 until the next block's first transfer or reset.
REQ-017: On the COUNT-th transfer, the state moves ACCUM->DONE; out_valid=1 and in_ready=0 from the next cycle (latency 1 cycle from final accept to result).
REQ-018: In DONE, out_sum and out_overflow are held stable while out_ready=0, for any number of cycles.
REQ-019: Output transfer occurs on a rising edge with out_valid=1 and out_ready=1; the state moves DONE->ACCUM, count <= 0, in_ready=1 from the next cycle.
REQ-020: No bypass: an operand presented in the same cycle as the output transfer is not accepted (one-cycle bubble per block).
REQ-021: Gaps in in_valid between transfers have no effect on the result; only accepted operands count.
REQ-022: out_sum and out_overflow are don't-care while out_valid=0 but are not X after reset.
REQ-023: COUNT-bit counter width is ceil(log2(COUNT+1)); it never exceeds COUNT.

Reset
REQ-024: While rst_n=0, asynchronously: state=ACCUM, count=0, acc=0, overflow=0, out_valid=0, in_ready=0, out_sum=0, out_overflow=0.
REQ-025: First rising edge after rst_n deasserts sets in_ready=1; no operand is accepted on that edge.
REQ-026: Reset mid-block or in DONE discards the partial or pending result entirely; no out_valid follows.

Verification
REQ-027: Defaults, out_ready=1, operands 1,2,3,4 back-to-back -> out_valid one cycle after 4th accept, out_sum=10, out_overflow=0.
REQ-028: Operands 255,1,0,0 -> out_sum=0, out_overflow=1 (remains 1 despite later no-carry adds).
REQ-029: Operands 5,5,5,5 with out_ready=0 for 5 cycles, in_valid=1 throughout -> out_sum=20 held, in_ready=0, no extra operand accepted; after handshake next block of 1,1,1,1 gives 4.
REQ-030: Operands 10,20,30,40 with 1-3 idle cycles between each -> out_sum=100, out_overflow=0.
REQ-031: Reset asserted after 2 operands (7,9) -> all outputs 0 immediately; after release, block 10,20,30,40 gives 100, overflow=0.
REQ-032: Block 200,100,0,0 (overflow=1) followed by block 5,5,5,5 -> second result out_sum=20, out_overflow=0.
